// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and
// registers the F/D payload, with exception, stall and delay-slot redirect handling.
`ifndef DS_OP_LEN
`define DS_OP_LEN 2
`endif
`ifndef DS_OP_NONE
`define DS_OP_NONE 2'd0
`endif
`ifndef DS_OP_SET
`define DS_OP_SET 2'd1
`endif
`ifndef DS_OP_CLEAR
`define DS_OP_CLEAR 2'd2
`endif
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif

module stage_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic [`DS_OP_LEN-1:0]    ds_op,
  input  logic                     exc_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              fd_pc,
  output logic [31:0]              fd_instr,
  output logic [`EXC_CODE_LEN-1:0] fd_exc,
  output logic                     fd_bd
);

  localparam logic [`EXC_CODE_LEN-1:0] EXC_ADEL = `EXC_CODE_LEN'd4;

  logic [31:0]              pc;
  logic                     fault;
  logic [31:0]              fetch_instr;
  logic [`EXC_CODE_LEN-1:0] fetch_exc;

  assign imem_addr   = pc;
  assign fault       = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  assign fetch_instr = fault ? 32'h0 : imem_rdata;
  assign fetch_exc   = fault ? EXC_ADEL : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      fd_pc    <= '0;
      fd_instr <= '0;
      fd_exc   <= '0;
      fd_bd    <= 1'b0;
    end else if (exc_req) begin
      pc       <= EXC_ENTRY;
      fd_pc    <= '0;
      fd_instr <= '0;
      fd_exc   <= '0;
      fd_bd    <= 1'b0;
    end else if (!stall) begin
      if (redirect_valid && ds_op == `DS_OP_CLEAR) begin
        // eret has no delay slot: the word already fetched is squashed
        pc       <= redirect_pc;
        fd_pc    <= '0;
        fd_instr <= '0;
        fd_exc   <= '0;
        fd_bd    <= 1'b0;
      end else begin
        pc       <= redirect_valid ? redirect_pc : pc + 32'd4;
        fd_pc    <= pc;
        fd_instr <= fetch_instr;
        fd_exc   <= fetch_exc;
        fd_bd    <= redirect_valid && (ds_op == `DS_OP_SET);
      end
    end
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Directed vector bench for stage_fetch: each record gives the inputs for one
// edge and the PC / F/D values expected right after that edge.
`ifndef DS_OP_LEN
`define DS_OP_LEN 2
`endif
`ifndef DS_OP_NONE
`define DS_OP_NONE 2'd0
`endif
`ifndef DS_OP_SET
`define DS_OP_SET 2'd1
`endif
`ifndef DS_OP_CLEAR
`define DS_OP_CLEAR 2'd2
`endif
`ifndef EXC_CODE_LEN
`define EXC_CODE_LEN 5
`endif

module tb_stage_fetch;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     stall = 1'b0;
  logic                     redirect_valid = 1'b0;
  logic [31:0]              redirect_pc = '0;
  logic [`DS_OP_LEN-1:0]    ds_op = `DS_OP_NONE;
  logic                     exc_req = 1'b0;
  logic [31:0]              imem_addr;
  logic [31:0]              imem_rdata = 32'h2408_0001;
  logic [31:0]              fd_pc;
  logic [31:0]              fd_instr;
  logic [`EXC_CODE_LEN-1:0] fd_exc;
  logic                     fd_bd;

  int checks = 0;
  int errors = 0;

  stage_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ds_op(ds_op), .exc_req(exc_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .fd_pc(fd_pc),
    .fd_instr(fd_instr), .fd_exc(fd_exc), .fd_bd(fd_bd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        exc;
    logic        rv;
    logic [1:0]  op;
    logic [31:0] rpc;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [4:0]  e_exc;
    logic        e_bd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] N = `DS_OP_NONE;
  localparam logic [1:0] S = `DS_OP_SET;
  localparam logic [1:0] C = `DS_OP_CLEAR;

  task automatic add(input logic rst, input logic stl, input logic exc, input logic rv,
                     input logic [1:0] op, input logic [31:0] rpc, input logic [31:0] rdata,
                     input logic [31:0] e_addr, input logic [31:0] e_pc,
                     input logic [31:0] e_instr, input logic [4:0] e_exc, input logic e_bd);
    vec_t v;
    v = '{rst, stl, exc, rv, op, rpc, rdata, e_addr, e_pc, e_instr, e_exc, e_bd};
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic [4:0] e_exc, input logic e_bd);
    check32({tag, " imem_addr"}, imem_addr, e_addr);
    check32({tag, " fd_pc"}, fd_pc, e_pc);
    check32({tag, " fd_instr"}, fd_instr, e_instr);
    check32({tag, " fd_exc"}, {27'b0, fd_exc}, {27'b0, e_exc});
    check32({tag, " fd_bd"}, {31'b0, fd_bd}, {31'b0, e_bd});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst stl exc rv op  rpc           rdata          addr          fd_pc         instr         exc bd
    add(1, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3000,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3004,     32'h3000,     32'h2408_0001, 0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3008,     32'h3004,     32'h2408_0001, 0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h300C,     32'h3008,     32'h2408_0001, 0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3010,     32'h300C,     32'h2408_0001, 0, 0);
    add(0, 0, 0, 1, S, 32'h3100,     32'h2408_0001, 32'h3100,     32'h3010,     32'h2408_0001, 0, 1);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3104,     32'h3100,     32'h2408_0001, 0, 0);
    add(0, 0, 0, 1, C, 32'h3018,     32'h2408_0001, 32'h3018,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'hAAAA_5555, 32'h301C,     32'h3018,     32'hAAAA_5555, 0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h1234_5678, 32'h3020,     32'h301C,     32'h1234_5678, 0, 0);
    add(0, 1, 0, 1, S, 32'h3200,     32'hDEAD_BEEF, 32'h3020,     32'h301C,     32'h1234_5678, 0, 0);
    add(0, 1, 0, 1, S, 32'h3200,     32'hDEAD_BEEF, 32'h3020,     32'h301C,     32'h1234_5678, 0, 0);
    add(0, 0, 0, 1, S, 32'h3200,     32'hDEAD_BEEF, 32'h3200,     32'h3020,     32'hDEAD_BEEF, 0, 1);
    add(0, 0, 0, 1, S, 32'h4190,     32'hDEAD_BEEF, 32'h4190,     32'h3200,     32'hDEAD_BEEF, 0, 1);
    add(0, 0, 0, 1, C, 32'h3044,     32'h0BAD_0BAD, 32'h3044,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 1, S, 32'h3002,     32'h1111_1111, 32'h3002,     32'h3044,     32'h1111_1111, 0, 1);
    add(0, 0, 0, 0, N, 32'h0,        32'h1111_1111, 32'h3006,     32'h3002,     32'h0,        4, 0);
    add(0, 0, 0, 1, S, 32'h7000,     32'h1111_1111, 32'h7000,     32'h3006,     32'h0,        4, 1);
    add(0, 0, 0, 0, N, 32'h0,        32'h1111_1111, 32'h7004,     32'h7000,     32'h0,        4, 0);
    add(0, 0, 0, 1, C, 32'h6FFC,     32'h2222_2222, 32'h6FFC,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2222_2222, 32'h7000,     32'h6FFC,     32'h2222_2222, 0, 0);
    add(0, 0, 0, 1, C, 32'h2FFC,     32'h2222_2222, 32'h2FFC,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2222_2222, 32'h3000,     32'h2FFC,     32'h0,        4, 0);
    add(0, 0, 0, 1, C, 32'hFFFF_FFFC, 32'h2222_2222, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2222_2222, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0,      4, 0);
    add(0, 1, 1, 1, S, 32'h5000,     32'h2222_2222, 32'h4180,     32'h0,        32'h0,        0, 0);
    add(1, 1, 0, 1, S, 32'h5000,     32'h2222_2222, 32'h3000,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3004,     32'h3000,     32'h2408_0001, 0, 0);
    add(0, 1, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3004,     32'h3000,     32'h2408_0001, 0, 0);
    add(1, 1, 0, 1, S, 32'h5000,     32'h2408_0001, 32'h3000,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h2408_0001, 32'h3004,     32'h3000,     32'h2408_0001, 0, 0);
    add(0, 0, 1, 1, C, 32'h5000,     32'h2408_0001, 32'h4180,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 0, N, 32'h0,        32'h3333_3333, 32'h4184,     32'h4180,     32'h3333_3333, 0, 0);

    foreach (vecs[i]) begin
      reset          = vecs[i].rst;
      stall          = vecs[i].stl;
      exc_req        = vecs[i].exc;
      redirect_valid = vecs[i].rv;
      ds_op          = vecs[i].op;
      redirect_pc    = vecs[i].rpc;
      imem_rdata     = vecs[i].rdata;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_pc,
                  vecs[i].e_instr, vecs[i].e_exc, vecs[i].e_bd);
    end

    // Long stall with a pending sequential fetch, then release.
    reset = 0; exc_req = 0; redirect_valid = 0; ds_op = N;
    stall = 1; imem_rdata = 32'h4444_4444;
    for (int k = 0; k < 3; k++) begin
      step();
      check_state($sformatf("hold%0d", k), 32'h4184, 32'h4180, 32'h3333_3333, 0, 0);
    end
    stall = 0;
    step();
    check_state("release", 32'h4188, 32'h4184, 32'h4444_4444, 0, 0);

    // Back-to-back delay-slot redirects: only the captured delay slot carries bd.
    redirect_valid = 1; ds_op = S; redirect_pc = 32'h3500; imem_rdata = 32'h5555_5555;
    step();
    check_state("ds1", 32'h3500, 32'h4188, 32'h5555_5555, 0, 1);
    redirect_valid = 0; ds_op = N;
    step();
    check_state("ds2", 32'h3504, 32'h3500, 32'h5555_5555, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter EXC_ENTRY, default 32'h0000_4180, meaning the exception handler entry address.
REQ-003 SHALL have parameters IM_LO, default 32'h0000_3000, and IM_HI, default 32'h0000_6FFC, meaning the inclusive legal fetch range.
REQ-004 SHALL have port clk  input  1  system clock; the only clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hazard stall: hold the PC and the F/D register.
REQ-007 SHALL have port redirect_valid  input  1  decode holds a control-transfer instruction (ds_op == `DS_OP_SET or `DS_OP_CLEAR).
REQ-008 SHALL have port redirect_pc  input  32  decode's computed next_pc.
REQ-009 SHALL have port ds_op  input  `DS_OP_LEN  decode delay-slot op: `DS_OP_NONE, `DS_OP_SET or `DS_OP_CLEAR.
REQ-010 SHALL have port exc_req  input  1  CP0 exception/interrupt taken this cycle.
REQ-011 SHALL have port imem_addr  output  32  combinational instruction-memory address, equal to pc.
REQ-012 SHALL have port imem_rdata  input  32  combinational instruction-memory read data for imem_addr.
REQ-013 SHALL have ports fd_pc (32), fd_instr (32), fd_exc (`EXC_CODE_LEN) and fd_bd (1), all outputs, forming the registered F/D payload (fd_bd = instruction is in a branch delay slot).

Function
REQ-014 SHALL hold internal register pc; imem_addr SHALL equal pc in every cycle.
REQ-015 SHALL flag a fetch fault when pc[1:0] != 0, pc < IM_LO or pc > IM_HI; on a fault the captured instruction SHALL be 32'h0 and the captured exc SHALL be 4 (AdEL); otherwise the captured exc SHALL be 0.
REQ-016 SHALL apply the following per-edge update priority: reset > exc_req > stall > redirect > sequential.
REQ-017 On exc_req: pc SHALL load EXC_ENTRY and the F/D register SHALL load a bubble ({pc, instr, exc, bd} = 0), even if stall is high.
REQ-018 On stall without exc_req: pc and all F/D outputs SHALL hold their values; redirect_valid and ds_op SHALL be ignored that cycle.
REQ-019 On redirect with ds_op == `DS_OP_SET: the F/D register SHALL capture the current fetch (the delay slot) with fd_bd = 1, and pc SHALL load redirect_pc.
REQ-020 On redirect with ds_op == `DS_OP_CLEAR (eret): the F/D register SHALL load a bubble (the fetched instruction is squashed, there is no delay slot), and pc SHALL load redirect_pc.
REQ-021 Sequential case: the F/D register SHALL capture {pc, imem_rdata or 0, exc, 0}, and pc SHALL load pc + 4 with 32-bit wrap-around and no overflow detection.
REQ-022 Fetch-to-F/D latency SHALL be exactly 1 cycle; pc SHALL advance at most one word per cycle.
REQ-023 An unaligned or out-of-range redirect_pc SHALL be accepted into pc unchanged; the fault SHALL be reported on the following fetch per REQ-015.
REQ-024 fd_pc SHALL carry the faulting pc unchanged so that CP0 can record EPC and BadVAddr.
REQ-025 fd_bd SHALL be 1 only for the instruction captured in the same edge as a `DS_OP_SET` redirect.

Reset
REQ-026 On reset: pc SHALL load RESET_PC and fd_pc, fd_instr, fd_exc and fd_bd SHALL load 0; reset SHALL override exc_req, stall and redirect.
REQ-027 A reset asserted mid-stall or mid-redirect SHALL discard the pending state; the first fetch after reset deassertion SHALL be at RESET_PC.

Verification
REQ-028 Bench SHALL cover: reset, then 3 free-running cycles with imem returning 32'h2408_0001 -> imem_addr sequence 0x3000, 0x3004, 0x3008; fd_pc lags by one cycle; fd_exc = 0; fd_bd = 0.
REQ-029 Bench SHALL cover: at pc 0x3010, redirect_valid = 1, ds_op = SET, redirect_pc = 0x3100 -> fd_pc = 0x3010 with fd_bd = 1; next imem_addr = 0x3100.
REQ-030 Bench SHALL cover: at pc 0x3020, stall held 2 cycles with redirect_valid = 1 -> pc and F/D unchanged for both cycles; the redirect takes effect on the first unstalled edge.
REQ-031 Bench SHALL cover: eret redirect (ds_op = CLEAR, redirect_pc = 0x3044) at pc 0x4190 -> F/D = all zeros; next imem_addr = 0x3044.
REQ-032 Bench SHALL cover: redirect_pc = 0x3002 -> the next F/D has fd_pc = 0x3002, fd_instr = 0, fd_exc = 4; likewise pc 0x7000 -> fd_exc = 4.
REQ-033 Bench SHALL cover: exc_req and stall both high with redirect_valid = 1 -> imem_addr = 0x4180 next cycle and F/D = bubble; then reset at the next edge -> imem_addr = 0x3000.
